// File: rtl/credit_link_tx.sv
// Sender end of a credit-flow-controlled link: buffers upstream flits and forwards
// one per cycle while the downstream FIFO is known to have a free slot.
module credit_link_tx #(
    parameter int CREDITS    = 5,
    parameter int DATA_WIDTH = 32,
    parameter int BUF_DEPTH  = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_WIDTH-1:0]      in_data,
    output logic                       out_push,
    output logic [DATA_WIDTH-1:0]      out_data,
    input  logic                       credit_return,
    output logic [$clog2(CREDITS):0]   credits,
    output logic                       busy,
    output logic                       credit_err
);

    localparam int CW = $clog2(CREDITS) + 1;
    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int NW = $clog2(BUF_DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic [NW-1:0]         count;
    logic                  accept;
    logic                  send;
    logic                  over_return;
    logic [CW-1:0]         credits_next;

    // Pointers wrap explicitly so non-power-of-two depths index correctly.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Credit counter clamps at CREDITS; an extra return is flagged separately.
    function automatic logic [CW-1:0] credit_sat(input logic [CW-1:0] cur,
                                                  input logic dec, input logic inc);
        logic [CW-1:0] nxt;
        nxt = cur;
        if (dec && !inc)
            nxt = cur - CW'(1);
        else if (inc && !dec && cur != CW'(CREDITS))
            nxt = cur + CW'(1);
        return nxt;
    endfunction

    // Ready is held low while reset is asserted and rises as soon as it releases.
    assign in_ready     = reset && (count < NW'(BUF_DEPTH));
    assign accept       = in_valid && in_ready;
    assign send         = (count != '0) && (credits != '0);
    assign over_return  = credit_return && !send && (credits == CW'(CREDITS));
    assign credits_next = credit_sat(credits, send, credit_return);
    assign busy         = (count != '0) || (credits != CW'(CREDITS));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            credits    <= CW'(CREDITS);
            credit_err <= 1'b0;
            out_push   <= 1'b0;
            out_data   <= '0;
        end else begin
            if (accept)
                wr_ptr <= ptr_inc(wr_ptr);
            if (send) begin
                rd_ptr   <= ptr_inc(rd_ptr);
                out_data <= mem[rd_ptr];
            end
            out_push <= send;
            count    <= count + NW'(accept) - NW'(send);
            credits  <= credits_next;
            if (over_return)
                credit_err <= 1'b1;
        end
    end

    // Flit storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (accept)
            mem[wr_ptr] <= in_data;
    end

endmodule

// File: doc/credit_link_tx.md
Name: credit_link_tx

Overview:
- Upstream (sender) end of a credit-flow-controlled router link; drives the push/data side of a downstream input-port FIFO.
- Takes flits from the local crossbar/output stage over a valid/ready handshake and holds them in a small internal buffer.
- Forwards a flit only when a downstream slot is guaranteed free. Downstream returns one credit per FIFO pop.
- Credit count mirrors the downstream FIFO's free-slot count, so the downstream never sees a push while full.

Parameters:
CREDITS, 5, downstream FIFO depth; initial and maximum credit count
DATA_WIDTH, 32, flit width in bits
BUF_DEPTH, 2, internal flit buffer entries (>=1)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
in_valid  input  1  upstream flit valid
in_ready  output  1  buffer can accept a flit this cycle
in_data  input  DATA_WIDTH  upstream flit
out_push  output  1  registered; one-cycle pulse per flit sent downstream
out_data  output  DATA_WIDTH  registered; flit accompanying out_push
credit_return  input  1  one pulse = one downstream slot freed (downstream pop)
credits  output  $clog2(CREDITS)+1  current credit count
busy  output  1  buffer non-empty OR credits < CREDITS
credit_err  output  1  sticky: credit returned while credits already == CREDITS

Behaviour:
- Reset (reset==0, asynchronous):
  - Outputs: out_push=0, out_data=0, credits=CREDITS, credit_err=0, in_ready=0.
  - Buffer pointers and count are zeroed; buffered flits are discarded.
  - After reset deasserts, in_ready=1 on the first cycle.
- Accept:
  - in_ready = (buf_count < BUF_DEPTH), derived from registered count only.
  - A flit is written when in_valid & in_ready at the rising edge.
  - No ready-through: a full buffer does not accept a flit even if it pops in the same cycle.
- Send decision (combinational): send = (buf_count > 0) & (credits > 0).
  - On send, the head is popped and registered into out_data with out_push=1 at the same edge.
  - out_push is 0 on any cycle without a send.
  - out_data holds its last value when out_push=0.
- Latency and throughput:
  - A flit accepted at edge k appears on out_push/out_data after edge k+1, at the earliest.
  - There is no same-cycle bypass from in_data.
  - Sustained throughput is one flit per cycle while credits > 0.
- Ordering: strict FIFO. Buffer pointers wrap at BUF_DEPTH-1 -> 0, so non-power-of-2 depths must work.
- Credit arithmetic: credits_next = credits - send + credit_return.
  - Simultaneous send and credit_return: credits unchanged.
  - credit_return at credits==0: no send in that cycle (decision uses registered credits). Counter becomes 1, and a send may occur next cycle.
  - credit_return with credits==CREDITS and no send: credits saturates at CREDITS and credit_err is set. credit_err clears only on reset.
  - Underflow is impossible by construction. Verification asserts credits never wraps.
- Simultaneous accept and send with 0 < buf_count < BUF_DEPTH: buf_count unchanged.
- busy is combinational from registered state.
- Invariant: credits + (flits sent but not yet credited) == CREDITS.

Test Plan:
- Reset, then push 0xA1, 0xA2, 0xA3 on consecutive cycles with no credit_return.
  - out_push is high for 3 consecutive cycles, starting one edge after 0xA1 is accepted.
  - out_data is 0xA1, 0xA2, 0xA3 in order; credits goes 5 -> 2.
- Offer 7 flits 0x01..0x07 with no credit_return.
  - 0x01..0x05 are sent and credits reaches 0.
  - 0x06 and 0x07 are buffered, in_ready=0, busy=1, and out_push stays 0.
- From the previous state, one credit_return pulse.
  - Next cycle credits=1; the following edge gives out_push=1 with out_data=0x06 and credits=0.
  - in_ready returns to 1.
- With credits=3 and a buffered flit, assert credit_return in the send cycle.
  - credits stays 3 and out_push=1 with the flit.
- When idle with credits=5, pulse credit_return.
  - credits stays 5; credit_err=1 and remains 1 across 10 further cycles of traffic.
- Drive reset low mid-stream between clock edges, with 2 flits buffered and credits=1.
  - Immediately: out_push=0, out_data=0, credits=5, credit_err=0, in_ready=0.
  - After release: in_ready=1 and no stale flit is ever pushed.
